sram_port_arbiter: RTL and testbench

- Shares one synchronous SRAM port between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Grants one requester per cycle, forwards its request to the SRAM, and routes the read data back to the owner one cycle later.
- Includes a starvation guard so that fetch is never locked out by back-to-back data accesses.
- Sits between the pipeline stages and the single unified SRAM.

---
 rtl/sram_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM port between fetch and data requesters
// Optional feature: define RDATA_HOLD_EN to keep read data stable between responses.
module sram_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req_en,
  input  logic [3:0]  inst_req_we,
  input  logic [31:0] inst_req_addr,
  input  logic [31:0] inst_req_wdata,
  output logic        inst_req_grant,
  output logic        inst_rdata_valid,
  output logic [31:0] inst_rdata,
  input  logic        data_req_en,
  input  logic [3:0]  data_req_we,
  input  logic [31:0] data_req_addr,
  input  logic [31:0] data_req_wdata,
  output logic        data_req_grant,
  output logic        data_rdata_valid,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INST = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  logic [CNT_W-1:0] starve_cnt;
  logic [1:0]       resp_owner;
  logic [1:0]       resp_owner_nxt;
  logic             contest;
  logic             starved;

  assign contest = inst_req_en & data_req_en;
  assign starved = (starve_cnt >= CNT_W'(STARVE_MAX));

  // Arbitration: data wins contests unless fetch has been starved long enough
  always_comb begin
    inst_req_grant = 1'b0;
    data_req_grant = 1'b0;
    if (!reset) begin
      if (contest) begin
        inst_req_grant = starved;
        data_req_grant = !starved;
      end else begin
        inst_req_grant = inst_req_en;
        data_req_grant = data_req_en;
      end
    end
  end

  // SRAM request mux: forward only the granted requester, zeros when idle
  always_comb begin
    sram_en    = inst_req_grant | data_req_grant;
    sram_we    = 4'h0;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    if (inst_req_grant) begin
      sram_we    = inst_req_we;
      sram_addr  = inst_req_addr;
      sram_wdata = inst_req_wdata;
    end else if (data_req_grant) begin
      sram_we    = data_req_we;
      sram_addr  = data_req_addr;
      sram_wdata = data_req_wdata;
    end
  end

  // Starvation counter: counts contests fetch lost, cleared whenever fetch is served
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (inst_req_grant) begin
      starve_cnt <= '0;
    end else if (contest && starve_cnt != {CNT_W{1'b1}}) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Response owner state register; reset drops any pending read response
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_owner <= OWN_NONE;
    end else begin
      resp_owner <= resp_owner_nxt;
    end
  end

  // Next owner: whoever got a read granted this cycle; writes and idle give NONE
  always_comb begin
    resp_owner_nxt = OWN_NONE;
    if (inst_req_grant && inst_req_we == 4'h0) begin
      resp_owner_nxt = OWN_INST;
    end else if (data_req_grant && data_req_we == 4'h0) begin
      resp_owner_nxt = OWN_DATA;
    end
  end

  // Response valids: one cycle after the read grant, suppressed during reset
  always_comb begin
    inst_rdata_valid = !reset && (resp_owner == OWN_INST);
    data_rdata_valid = !reset && (resp_owner == OWN_DATA);
  end

`ifdef RDATA_HOLD_EN
  logic [31:0] inst_hold;
  logic [31:0] data_hold;

  // Capture each requester's read data so it stays visible while the stage stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_hold <= 32'h0;
      data_hold <= 32'h0;
    end else begin
      if (inst_rdata_valid) inst_hold <= sram_rdata;
      if (data_rdata_valid) data_hold <= sram_rdata;
    end
  end

  // Read data: live SRAM data in the response cycle, held value otherwise
  always_comb begin
    inst_rdata = 32'h0;
    data_rdata = 32'h0;
    if (!reset) begin
      inst_rdata = inst_rdata_valid ? sram_rdata : inst_hold;
      data_rdata = data_rdata_valid ? sram_rdata : data_hold;
    end
  end
`else
  // Read data: SRAM data passed straight through, meaningful only with valid
  always_comb begin
    inst_rdata = reset ? 32'h0 : sram_rdata;
    data_rdata = reset ? 32'h0 : sram_rdata;
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 3;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req_en;
  logic [3:0]  inst_req_we;
  logic [31:0] inst_req_addr;
  logic [31:0] inst_req_wdata;
  logic        inst_req_grant;
  logic        inst_rdata_valid;
  logic [31:0] inst_rdata;
  logic        data_req_en;
  logic [3:0]  data_req_we;
  logic [31:0] data_req_addr;
  logic [31:0] data_req_wdata;
  logic        data_req_grant;
  logic        data_rdata_valid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int vec_cnt = 0;
  int err_cnt = 0;

  sram_port_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .inst_req_en(inst_req_en), .inst_req_we(inst_req_we),
    .inst_req_addr(inst_req_addr), .inst_req_wdata(inst_req_wdata),
    .inst_req_grant(inst_req_grant), .inst_rdata_valid(inst_rdata_valid),
    .inst_rdata(inst_rdata),
    .data_req_en(data_req_en), .data_req_we(data_req_we),
    .data_req_addr(data_req_addr), .data_req_wdata(data_req_wdata),
    .data_req_grant(data_req_grant), .data_rdata_valid(data_rdata_valid),
    .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: 256 words indexed by addr[9:2], byte writes, 1-cycle read
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (sram_en && sram_we != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      sram_rdata <= $urandom;
    end else if (sram_en) begin
      sram_rdata <= mem[sram_addr[9:2]];
    end else begin
      sram_rdata <= $urandom;
    end
  end

  typedef struct {
    logic rst;
    logic ie; logic [3:0] iwe; logic [31:0] iaddr; logic [31:0] iwd;
    logic de; logic [3:0] dwe; logic [31:0] daddr; logic [31:0] dwd;
    logic eig; logic edg; logic eiv; logic edv;
    logic [31:0] erd;
    int ecnt;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(
    input logic rst,
    input logic ie, input logic [3:0] iwe, input logic [31:0] iaddr, input logic [31:0] iwd,
    input logic de, input logic [3:0] dwe, input logic [31:0] daddr, input logic [31:0] dwd,
    input logic eig, input logic edg, input logic eiv, input logic edv,
    input logic [31:0] erd, input int ecnt);
    vec_t v;
    v.rst = rst; v.ie = ie; v.iwe = iwe; v.iaddr = iaddr; v.iwd = iwd;
    v.de = de; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.eig = eig; v.edg = edg; v.eiv = eiv; v.edv = edv; v.erd = erd; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst,
    input logic ie, input logic [3:0] iwe, input logic [31:0] iaddr, input logic [31:0] iwd,
    input logic de, input logic [3:0] dwe, input logic [31:0] daddr, input logic [31:0] dwd);
    @(negedge clk);
    reset = rst;
    inst_req_en = ie; inst_req_we = iwe; inst_req_addr = iaddr; inst_req_wdata = iwd;
    data_req_en = de; data_req_we = dwe; data_req_addr = daddr; data_req_wdata = dwd;
    #1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Reference model state
  logic [31:0] exp_mem [256];
  int          streak;
  int          pend;       // 0 none, 1 inst, 2 data
  logic [31:0] pend_val;
  logic [31:0] ihold, dhold;

  localparam logic [31:0] I1 = 32'h1c000000;
  localparam logic [31:0] I2 = 32'h1c000004;
  localparam logic [31:0] A1 = 32'hAAAA0001;
  localparam logic [31:0] A2 = 32'hAAAA0002;
  localparam logic [31:0] JW = 32'h5555_0000;

  initial begin
    logic        r_rst, r_ie, r_de, gi, gd;
    logic [3:0]  r_iwe, r_dwe, ewe;
    logic [31:0] r_ia, r_da, r_iwd, r_dwd, ea, ewd, w;
    int          k;

    reset = 1'b1;
    inst_req_en = 1'b0; inst_req_we = 4'h0; inst_req_addr = 32'h0; inst_req_wdata = 32'h0;
    data_req_en = 1'b0; data_req_we = 4'h0; data_req_addr = 32'h0; data_req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;

    // ---------- directed table ----------
    tbl[0]  = mk(1, 1,0,I1,JW, 1,0,I2,JW,                0,0,0,0, 0, -1);
    tbl[1]  = mk(1, 0,0,0,0,   0,0,0,0,                  0,0,0,0, 0, 0);
    tbl[2]  = mk(0, 0,0,0,0,   1,4'hF,I1,A1,             0,1,0,0, 0, 0);
    tbl[3]  = mk(0, 0,0,0,0,   1,4'hF,I2,A2,             0,1,0,0, 0, 0);
    tbl[4]  = mk(0, 1,0,I1,JW, 0,0,0,0,                  1,0,0,0, 0, 0);
    tbl[5]  = mk(0, 1,0,I2,JW, 0,0,0,0,                  1,0,1,0, A1, 0);
    tbl[6]  = mk(0, 0,0,0,0,   0,0,0,0,                  0,0,1,0, A2, 0);
    tbl[7]  = mk(0, 0,0,0,0,   0,0,0,0,                  0,0,0,0, 0, 0);
    for (int i = 8; i <= 11; i++)
      tbl[i] = mk(0, 1,0,I1,JW, 1,0,I2,JW, 0,1,0,(i > 8), A2, i - 8);
    tbl[12] = mk(0, 1,0,I1,JW, 1,0,I2,JW,                1,0,0,1, A2, 4);
    tbl[13] = mk(0, 1,0,I1,JW, 1,0,I2,JW,                0,1,1,0, A1, 0);
    tbl[14] = mk(0, 0,0,0,0,   0,0,0,0,                  0,0,0,1, A2, 1);
    tbl[15] = mk(0, 0,0,0,0,   1,4'hF,32'h100,32'h12345678, 0,1,0,0, 0, 1);
    tbl[16] = mk(0, 1,0,32'h100,JW, 0,0,0,0,             1,0,0,0, 0, 1);
    tbl[17] = mk(0, 0,0,0,0,   0,0,0,0,                  0,0,1,0, 32'h12345678, 0);
    tbl[18] = mk(0, 0,0,0,0,   1,0,32'h100,JW,           0,1,0,0, 0, 0);
    tbl[19] = mk(1, 1,0,I1,JW, 1,0,I2,JW,                0,0,0,0, 0, 0);
    tbl[20] = mk(0, 0,0,0,0,   0,0,0,0,                  0,0,0,0, 0, 0);
    tbl[21] = mk(0, 0,0,0,0,   1,0,I1,JW,                0,1,0,0, 0, 0);
    tbl[22] = mk(0, 0,0,0,0,   0,0,0,0,                  0,0,0,1, A1, 0);

    for (int i = 0; i < 23; i++) begin
      vec_t v;
      v = tbl[i];
      drive(v.rst, v.ie, v.iwe, v.iaddr, v.iwd, v.de, v.dwe, v.daddr, v.dwd);
      ewe = 4'h0; ea = 32'h0; ewd = 32'h0;
      if (v.eig) begin ewe = v.iwe; ea = v.iaddr; ewd = v.iwd; end
      else if (v.edg) begin ewe = v.dwe; ea = v.daddr; ewd = v.dwd; end
      chk($sformatf("tbl%0d inst_grant", i), 32'(inst_req_grant), 32'(v.eig));
      chk($sformatf("tbl%0d data_grant", i), 32'(data_req_grant), 32'(v.edg));
      chk($sformatf("tbl%0d sram_en", i), 32'(sram_en), 32'(v.eig | v.edg));
      chk($sformatf("tbl%0d sram_we", i), 32'(sram_we), 32'(ewe));
      chk($sformatf("tbl%0d sram_addr", i), sram_addr, ea);
      chk($sformatf("tbl%0d sram_wdata", i), sram_wdata, ewd);
      chk($sformatf("tbl%0d inst_valid", i), 32'(inst_rdata_valid), 32'(v.eiv));
      chk($sformatf("tbl%0d data_valid", i), 32'(data_rdata_valid), 32'(v.edv));
      if (v.eiv) chk($sformatf("tbl%0d inst_rdata", i), inst_rdata, v.erd);
      if (v.edv) chk($sformatf("tbl%0d data_rdata", i), data_rdata, v.erd);
      if (v.rst) begin
        chk($sformatf("tbl%0d inst_rdata_rst", i), inst_rdata, 32'h0);
        chk($sformatf("tbl%0d data_rdata_rst", i), data_rdata, 32'h0);
      end
      if (v.ecnt >= 0) chk($sformatf("tbl%0d starve_cnt", i), 32'(dut.starve_cnt), 32'(v.ecnt));
    end

`ifdef RDATA_HOLD_EN
    // ---------- hold register sequence ----------
    drive(0, 0,0,0,0, 1,4'hF,32'h40,32'hDEADBEEF);
    chk("hold data_grant", 32'(data_req_grant), 32'h1);
    drive(0, 1,0,32'h40,JW, 0,0,0,0);
    chk("hold inst_grant", 32'(inst_req_grant), 32'h1);
    drive_idle();
    chk("hold resp_valid", 32'(inst_rdata_valid), 32'h1);
    chk("hold resp_rdata", inst_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      chk($sformatf("hold idle%0d valid", i), 32'(inst_rdata_valid), 32'h0);
      chk($sformatf("hold idle%0d rdata", i), inst_rdata, 32'hDEADBEEF);
    end
    drive(0, 0,0,0,0, 1,0,I1,JW);
    chk("hold under data read", inst_rdata, 32'hDEADBEEF);
    drive_idle();
    chk("hold data resp", data_rdata, A1);
    chk("hold inst kept", inst_rdata, 32'hDEADBEEF);
`endif

    // ---------- randomized run against reference model ----------
    @(negedge clk);
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    streak = 0; pend = 0; pend_val = 32'h0; ihold = 32'h0; dhold = 32'h0;
    for (int n = 0; n < 1500; n++) begin
      r_rst = (n < 2) || ($urandom_range(0, 63) == 0);
      r_ie  = ($urandom_range(0, 3) != 0);
      r_de  = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 3);
      r_iwe = (k == 2) ? 4'hF : (k == 3) ? 4'($urandom) : 4'h0;
      k = $urandom_range(0, 3);
      r_dwe = (k == 2) ? 4'hF : (k == 3) ? 4'($urandom) : 4'h0;
      r_ia  = 32'($urandom_range(0, 15)) << 2;
      r_da  = 32'($urandom_range(0, 15)) << 2;
      r_iwd = $urandom;
      r_dwd = $urandom;
      drive(r_rst, r_ie, r_iwe, r_ia, r_iwd, r_de, r_dwe, r_da, r_dwd);

      if (r_rst) begin gi = 0; gd = 0; end
      else if (r_ie && r_de) begin gi = (streak >= STARVE_MAX); gd = !gi; end
      else begin gi = r_ie; gd = r_de; end
      ewe = gi ? r_iwe : gd ? r_dwe : 4'h0;
      ea  = gi ? r_ia  : gd ? r_da  : 32'h0;
      ewd = gi ? r_iwd : gd ? r_dwd : 32'h0;

      chk("rnd inst_grant", 32'(inst_req_grant), 32'(gi));
      chk("rnd data_grant", 32'(data_req_grant), 32'(gd));
      chk("rnd sram_en", 32'(sram_en), 32'(gi | gd));
      chk("rnd sram_we", 32'(sram_we), 32'(ewe));
      chk("rnd sram_addr", sram_addr, ea);
      chk("rnd sram_wdata", sram_wdata, ewd);
      chk("rnd inst_valid", 32'(inst_rdata_valid), 32'(!r_rst && pend == 1));
      chk("rnd data_valid", 32'(data_rdata_valid), 32'(!r_rst && pend == 2));
      if (r_rst) begin
        chk("rnd inst_rdata_rst", inst_rdata, 32'h0);
        chk("rnd data_rdata_rst", data_rdata, 32'h0);
      end else begin
        if (pend == 1) chk("rnd inst_rdata", inst_rdata, pend_val);
        if (pend == 2) chk("rnd data_rdata", data_rdata, pend_val);
`ifdef RDATA_HOLD_EN
        if (pend != 1) chk("rnd inst_hold", inst_rdata, ihold);
        if (pend != 2) chk("rnd data_hold", data_rdata, dhold);
`endif
      end

      if (r_rst) begin
        streak = 0; pend = 0; ihold = 32'h0; dhold = 32'h0;
      end else begin
        if (pend == 1) ihold = pend_val;
        if (pend == 2) dhold = pend_val;
        if (gi) streak = 0;
        else if (r_ie && r_de) streak = (streak < CNT_MAX) ? streak + 1 : CNT_MAX;
        pend = 0;
        if (gi || gd) begin
          if (ewe == 4'h0) begin
            pend = gi ? 1 : 2;
            pend_val = exp_mem[ea[9:2]];
          end else begin
            w = exp_mem[ea[9:2]];
            for (int b = 0; b < 4; b++) if (ewe[b]) w[b*8 +: 8] = ewd[b*8 +: 8];
            exp_mem[ea[9:2]] = w;
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
